// File: rtl/vram_console_pkg.sv
// vram_console_pkg
// Shared definitions for the VRAM console writer:
//   - VRAM cell field positions (bold, underline, fg, bg, char)
//   - text grid geometry (64 columns x 16 rows)
//   - control codes understood by the writer
//   - FSM state and cursor-operation encodings
//   - helpers to classify bytes and pack a cell word
package vram_console_pkg;

  localparam int COLS = 64;
  localparam int ROWS = 16;

  // Cell word layout: {bold, underline, fg[2:0], bg[2:0], char[7:0]}
  localparam int CELL_BOLD  = 15;
  localparam int CELL_UL    = 14;
  localparam int CELL_FG_HI = 13;
  localparam int CELL_FG_LO = 11;
  localparam int CELL_BG_HI = 10;
  localparam int CELL_BG_LO = 8;
  localparam int CELL_CH_HI = 7;
  localparam int CELL_CH_LO = 0;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WRITE        = 3'd1,
    ST_CLR_ROW      = 3'd2,
    ST_CLR_ALL      = 3'd3,
    ST_DRAW_REQ     = 3'd4,
    ST_DRAW_WAIT_LO = 3'd5,
    ST_DRAW_WAIT_HI = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CUR_NONE = 3'd0,
    CUR_INC  = 3'd1,
    CUR_NL   = 3'd2,
    CUR_CR   = 3'd3,
    CUR_BS   = 3'd4,
    CUR_HOME = 3'd5
  } cur_op_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  // Attribute byte is [7] bold, [6] underline, [5:3] fg, [2:0] bg.
  function automatic logic [15:0] cell_pack(input logic [7:0] attr, input logic [7:0] ch);
    logic [15:0] c;
    c = '0;
    c[CELL_BOLD]              = attr[7];
    c[CELL_UL]                = attr[6];
    c[CELL_FG_HI:CELL_FG_LO]  = attr[5:3];
    c[CELL_BG_HI:CELL_BG_LO]  = attr[2:0];
    c[CELL_CH_HI:CELL_CH_LO]  = ch;
    return c;
  endfunction

endpackage

// File: rtl/vram_console_cursor.sv
// vram_console_cursor
// Row/column cursor of the 64x16 text grid. Both coordinates wrap
// modulo their width (6-bit col, 4-bit row).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   op           cursor operation for this cycle (cur_op_t encoding)
//   row, col     current cursor position
//   row_entry    high when this cycle's increment wraps col 63->0
module vram_console_cursor
  import vram_console_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] op,
  output logic [3:0] row,
  output logic [5:0] col,
  output logic       row_entry
);

  logic at_last_col;
  assign at_last_col = (col == 6'(COLS - 1));
  assign row_entry   = (op == CUR_INC) && at_last_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else begin
      case (op)
        CUR_INC: begin
          col <= col + 6'd1;
          if (at_last_col) row <= row + 4'd1;
        end
        CUR_NL: begin
          col <= '0;
          row <= row + 4'd1;
        end
        CUR_CR:   col <= '0;
        CUR_BS:   if (col != 6'd0) col <= col - 6'd1;
        CUR_HOME: begin
          col <= '0;
          row <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vram_console_writer.sv
// vram_console_writer
// Turns a byte stream of characters/control codes into VRAM cell writes
// on a 64x16 text grid and requests a GPU redraw after the input has been
// quiet for IDLE_CYCLES cycles while something was written.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     byte handshake; in_data char/code, in_attr attribute
//   vram_enable/write     chip select and write strobe (identical)
//   vram_addr             {row, col}; vram_data_w cell word (0 = blank)
//   vram_lock             GPU owns VRAM; no write is issued while high
//   sig_ready/sig_draw    GPU idle indication / one-cycle draw request
module vram_console_writer
  import vram_console_pkg::*;
#(
  parameter int         IDLE_CYCLES  = 16,
  parameter logic [7:0] DEFAULT_ATTR = 8'h38
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic [7:0]  in_attr,
  output logic        vram_enable,
  output logic        vram_write,
  output logic [9:0]  vram_addr,
  output logic [15:0] vram_data_w,
  input  logic        vram_lock,
  input  logic        sig_ready,
  output logic        sig_draw
);

  localparam int IC_W = $clog2(IDLE_CYCLES + 1);

  // DEFAULT_ATTR only documents the attribute the bench drives.
  logic unused_default_attr;
  assign unused_default_attr = ^DEFAULT_ATTR;

  state_t           state_reg, state_next;
  logic [9:0]       clr_cnt_reg, clr_cnt_next;
  logic [15:0]      cell_reg, cell_next;
  logic             dirty_reg;
  logic [IC_W-1:0]  idle_cnt_reg;
  logic [2:0]       cur_op;
  logic [3:0]       row;
  logic [5:0]       col;
  logic             row_entry;
  logic             accept;
  logic             draw_due;

  vram_console_cursor u_cursor (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (cur_op),
    .row       (row),
    .col       (col),
    .row_entry (row_entry)
  );

  assign in_ready    = (state_reg == ST_IDLE) && !vram_lock;
  assign accept      = in_valid && in_ready;
  assign vram_enable = !vram_lock && ((state_reg == ST_WRITE) ||
                                      (state_reg == ST_CLR_ROW) ||
                                      (state_reg == ST_CLR_ALL));
  assign vram_write  = vram_enable;
  assign sig_draw    = (state_reg == ST_DRAW_REQ);
  // A byte on the input pre-empts a pending draw request.
  assign draw_due    = !in_valid && dirty_reg && sig_ready &&
                       (idle_cnt_reg >= IC_W'(IDLE_CYCLES));

  // Address is held while locked because it is a function of state only.
  always_comb begin
    vram_addr   = '0;
    vram_data_w = '0;
    case (state_reg)
      ST_WRITE: begin
        vram_addr   = {row, col};
        vram_data_w = cell_reg;
      end
      ST_CLR_ROW: vram_addr = {row, clr_cnt_reg[5:0]};
      ST_CLR_ALL: vram_addr = clr_cnt_reg;
      default: ;
    endcase
  end

  // Cursor operation is decoded separately so row_entry can feed the
  // state decision without a combinational self-loop.
  always_comb begin
    cur_op = CUR_NONE;
    case (state_reg)
      ST_IDLE: begin
        if (accept && !is_printable(in_data)) begin
          case (in_data)
            CH_LF:   cur_op = CUR_NL;
            CH_CR:   cur_op = CUR_CR;
            CH_BS:   cur_op = CUR_BS;
            default: cur_op = CUR_NONE;
          endcase
        end
      end
      ST_WRITE:   if (!vram_lock) cur_op = CUR_INC;
      ST_CLR_ALL: if (!vram_lock && (clr_cnt_reg == 10'd1023)) cur_op = CUR_HOME;
      default: ;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    cell_next    = cell_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (is_printable(in_data)) begin
            state_next = ST_WRITE;
            cell_next  = cell_pack(in_attr, in_data);
          end else if (in_data == CH_LF) begin
            state_next   = ST_CLR_ROW;
            clr_cnt_next = '0;
          end else if (in_data == CH_FF) begin
            state_next   = ST_CLR_ALL;
            clr_cnt_next = '0;
          end
        end else if (draw_due) begin
          state_next = ST_DRAW_REQ;
        end
      end
      ST_WRITE: begin
        if (!vram_lock) begin
          if (row_entry) begin
            state_next   = ST_CLR_ROW;
            clr_cnt_next = '0;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_CLR_ROW: begin
        if (!vram_lock) begin
          if (clr_cnt_reg[5:0] == 6'(COLS - 1)) state_next = ST_IDLE;
          else clr_cnt_next = clr_cnt_reg + 10'd1;
        end
      end
      ST_CLR_ALL: begin
        if (!vram_lock) begin
          if (clr_cnt_reg == 10'd1023) state_next = ST_IDLE;
          else clr_cnt_next = clr_cnt_reg + 10'd1;
        end
      end
      ST_DRAW_REQ:     state_next = ST_DRAW_WAIT_LO;
      ST_DRAW_WAIT_LO: if (!sig_ready) state_next = ST_DRAW_WAIT_HI;
      ST_DRAW_WAIT_HI: if (sig_ready) state_next = ST_IDLE;
      default:         state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      clr_cnt_reg  <= '0;
      cell_reg     <= '0;
      dirty_reg    <= 1'b0;
      idle_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
      cell_reg    <= cell_next;
      if (sig_draw) dirty_reg <= 1'b0;
      else if (vram_enable) dirty_reg <= 1'b1;
      // Counts quiet cycles only while staying in IDLE; saturates.
      if ((state_reg == ST_IDLE) && (state_next == ST_IDLE) && !in_valid) begin
        if (idle_cnt_reg != IC_W'(IDLE_CYCLES)) idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end else begin
        idle_cnt_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vram_console_writer.sv
// Testbench for vram_console_writer: a grid-level model turns each accepted
// byte into the list of cell writes it must cause; a per-cycle monitor
// matches every VRAM write against that list.
module tb_vram_console_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic [7:0]  in_attr = 8'h00;
  logic        vram_enable;
  logic        vram_write;
  logic [9:0]  vram_addr;
  logic [15:0] vram_data_w;
  logic        vram_lock = 1'b0;
  logic        sig_ready = 1'b0;
  logic        sig_draw;

  vram_console_writer #(.IDLE_CYCLES(16), .DEFAULT_ATTR(8'h38)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_attr     (in_attr),
    .vram_enable (vram_enable),
    .vram_write  (vram_write),
    .vram_addr   (vram_addr),
    .vram_data_w (vram_data_w),
    .vram_lock   (vram_lock),
    .sig_ready   (sig_ready),
    .sig_draw    (sig_draw)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];

  int total = 0, bad = 0;
  int m_row = 0, m_col = 0;
  bit m_dirty = 0;
  int cyc = 0, wr_cnt = 0, draw_cnt = 0;
  int last_addr = -1, last_data = -1, last_wr_cyc = 0, draw_cyc = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Grid model: what writes a byte must produce, in order.
  task automatic push_row(input int r);
    for (int c = 0; c < 64; c++) exp_q.push_back('{r * 64 + c, 0});
  endtask

  task automatic model_feed(input logic [7:0] d, input logic [7:0] a);
    if (d >= 8'h20 && d <= 8'h7E) begin
      exp_q.push_back('{m_row * 64 + m_col, int'({a, d})});
      m_col++;
      if (m_col == 64) begin
        m_col = 0;
        m_row = (m_row + 1) % 16;
        push_row(m_row);
      end
    end else if (d == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % 16;
      push_row(m_row);
    end else if (d == 8'h0D) begin
      m_col = 0;
    end else if (d == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (d == 8'h0C) begin
      for (int i = 0; i < 1024; i++) exp_q.push_back('{i, 0});
      m_row = 0;
      m_col = 0;
    end
  endtask

  // Per-cycle monitor, sampled mid-cycle.
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    check("write_strobe_eq_enable", vram_write, vram_enable);
    if (vram_enable) begin
      wr_cnt++;
      check("no_write_while_locked", vram_lock, 0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h want no write", vram_addr, vram_data_w);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", vram_addr, e.addr);
        check("wr_data", vram_data_w, e.data);
      end
      m_dirty = 1;
      last_addr = vram_addr;
      last_data = vram_data_w;
      last_wr_cyc = cyc;
    end
    if (sig_draw) begin
      draw_cnt++;
      draw_cyc = cyc;
      check("draw_only_when_dirty", m_dirty, 1);
      m_dirty = 0;
    end
  end

  task automatic send(input logic [7:0] d, input logic [7:0] a);
    int budget;
    budget = 3000;
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_data  = d;
    in_attr  = a;
    while (!in_ready && budget > 0) begin
      @(posedge clk); #2;
      budget--;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready 0 want 1 for byte %0h", d);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_feed(d, a);
    #2 in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 3000;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, b;
    // ---- reset ----
    #3;
    check("rst_enable", vram_enable, 0);
    check("rst_addr", vram_addr, 0);
    check("rst_data", vram_data_w, 0);
    check("rst_draw", sig_draw, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #2;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_enable", vram_enable, 0);

    // ---- 'A' then idle draw ----
    sig_ready = 1'b1;
    send(8'h41, 8'h38);
    drain("drain_A");
    check("A_addr", last_addr, 0);
    check("A_data", last_data, 16'h3841);
    check("A_count", wr_cnt, 1);
    b = 60;
    while (draw_cnt == 0 && b > 0) begin @(posedge clk); b--; end
    check("draw_seen", draw_cnt, 1);
    check("draw_latency", draw_cyc - last_wr_cyc, 18);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check("hs_ready_hi_in_ready", in_ready, 0);
    end
    sig_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      check("hs_ready_lo_in_ready", in_ready, 0);
    end
    sig_ready = 1'b1;
    b = 5;
    while (!in_ready && b > 0) begin @(posedge clk); #2; b--; end
    check("hs_done_in_ready", in_ready, 1);
    check("single_draw", draw_cnt, 1);
    sig_ready = 1'b0;

    // ---- full row of 'x' with row entry ----
    send(8'h0D, 8'h38);
    for (int i = 0; i < 64; i++) send(8'h78, 8'h38);
    drain("drain_row");
    check("row_clear_last_addr", last_addr, 127);
    check("row_clear_last_data", last_data, 0);
    send(8'h79, 8'h38);
    drain("drain_y");
    check("y_addr", last_addr, 64);
    check("y_data", last_data, 16'h3879);

    // ---- LF wrap from row 15 ----
    for (int i = 0; i < 14; i++) send(8'h0A, 8'h38);
    for (int i = 0; i < 5; i++) send(8'h7A, 8'h38);
    send(8'h0A, 8'h38);
    drain("drain_lf_wrap");
    check("lf_wrap_last_addr", last_addr, 63);
    send(8'h43, 8'h07);
    drain("drain_C");
    check("C_addr", last_addr, 0);
    check("C_data", last_data, 16'h0743);

    // ---- BS, ignored byte ----
    send(8'h08, 8'h38);
    send(8'h08, 8'h38);
    send(8'h44, 8'h38);
    drain("drain_D");
    check("bs_D_addr", last_addr, 0);
    send(8'h01, 8'h38);
    send(8'h45, 8'h38);
    drain("drain_E");
    check("ignored_E_addr", last_addr, 1);

    // ---- FF ----
    snap = wr_cnt;
    send(8'h0C, 8'h38);
    drain("drain_ff");
    check("ff_count", wr_cnt - snap, 1024);
    check("ff_last_addr", last_addr, 1023);
    send(8'h42, 8'hC5);
    drain("drain_B");
    check("B_addr", last_addr, 0);
    check("B_data", last_data, 16'hC542);

    // ---- lock during CLR_ROW ----
    send(8'h0A, 8'h38);
    repeat (5) @(posedge clk);
    #2 vram_lock = 1'b1;
    snap = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      check("lock_in_ready", in_ready, 0);
    end
    check("lock_no_writes", wr_cnt - snap, 0);
    vram_lock = 1'b0;
    drain("drain_lock");
    check("lock_last_addr", last_addr, 127);
    send(8'h46, 8'h38);
    drain("drain_F");
    check("F_addr", last_addr, 64);

    // ---- reset mid-clear ----
    send(8'h0C, 8'h38);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    m_dirty = 0;
    #1;
    check("midrst_enable", vram_enable, 0);
    check("midrst_addr", vram_addr, 0);
    check("midrst_data", vram_data_w, 0);
    check("midrst_draw", sig_draw, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #2;
    check("midrst_in_ready", in_ready, 1);
    send(8'h47, 8'h38);
    drain("drain_G");
    check("G_addr", last_addr, 0);
    check("G_data", last_data, 16'h3847);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
